// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU core and its bench.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_NO  = 3'b000,
        OP_ADD = 3'b001,
        OP_AND = 3'b010,
        OP_XOR = 3'b011,
        OP_MUL = 3'b100,
        OP_RST = 3'b111
    } operation_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        MUL  = 2'd2
    } state_t;

    localparam int          MUL_STEPS = 8;
    localparam logic [2:0]  MUL_LAST  = 3'(MUL_STEPS - 1);

    // Single-cycle ops; the add keeps its carry in bit 8.
    function automatic logic [15:0] alu_logic(input logic [2:0] op,
                                              input logic [7:0] a,
                                              input logic [7:0] b);
        logic [15:0] r;
        case (op)
            OP_ADD:  r = {7'b000_0000, ({1'b0, a} + {1'b0, b})};
            OP_AND:  r = {8'h00, a & b};
            OP_XOR:  r = {8'h00, a ^ b};
            default: r = 16'h0000;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/alu_if.sv
// Operand/opcode/start request bus and the result/done/busy response.
interface alu_if;
    logic [7:0]  A;
    logic [7:0]  B;
    logic [2:0]  op;
    logic        start;
    logic        done;
    logic [15:0] result;
    logic        busy;

    modport master (output A, B, op, start, input done, result, busy);
    modport slave  (input A, B, op, start, output done, result, busy);
endinterface

// File: rtl/alu_mult_seq.sv
// Iterative 8-step shift-add multiplier; product shows the value after the current step.
module alu_mult_seq
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic        busy,
    output logic        last,
    output logic [15:0] product
);

    logic [15:0] mcand_q;
    logic [15:0] acc_q;
    logic [7:0]  mplier_q;
    logic [2:0]  cnt_q;
    logic        busy_q;
    logic [15:0] acc_step_s;

    // Accumulator value once the current multiplier bit is applied.
    always_comb begin
        acc_step_s = acc_q;
        if (mplier_q[0]) begin
            acc_step_s = acc_q + mcand_q;
        end else begin
            acc_step_s = acc_q;
        end
    end

    // Datapath registers: load captures operands, each busy edge performs one step.
    always_ff @(posedge clk) begin
        if (reset) begin
            mcand_q  <= 16'h0000;
            acc_q    <= 16'h0000;
            mplier_q <= 8'h00;
            cnt_q    <= 3'd0;
            busy_q   <= 1'b0;
        end else if (load) begin
            mcand_q  <= {8'h00, a};
            acc_q    <= 16'h0000;
            mplier_q <= b;
            cnt_q    <= 3'd0;
            busy_q   <= 1'b1;
        end else if (busy_q) begin
            acc_q    <= acc_step_s;
            mcand_q  <= {mcand_q[14:0], 1'b0};
            mplier_q <= {1'b0, mplier_q[7:1]};
            cnt_q    <= cnt_q + 3'd1;
            busy_q   <= (cnt_q != MUL_LAST);
        end else begin
            busy_q   <= 1'b0;
        end
    end

    assign busy    = busy_q;
    assign last    = busy_q && (cnt_q == MUL_LAST);
    assign product = acc_step_s;

endmodule

// File: rtl/alu_core.sv
// Registered 8-bit ALU: edge-triggered accept, 1-cycle logic/add, 8-cycle multiply.
module alu_core
    import alu_pkg::*;
(
    input  logic clk,
    input  logic reset,
    alu_if.slave bus
);

    state_t      state_q, state_d;
    logic        start_q;
    logic [7:0]  a_q, b_q;
    logic [2:0]  op_q;
    logic [15:0] result_q, result_d;
    logic        done_q, done_d;
    logic        busy_q;
    logic        accept_s;
    logic        load_s;
    logic        last_s;
    logic        mult_busy_s;
    logic [15:0] product_s;

    assign accept_s = bus.start && !start_q && (state_q == IDLE);

    alu_mult_seq u_mult (
        .clk     (clk),
        .reset   (reset),
        .load    (load_s),
        .a       (bus.A),
        .b       (bus.B),
        .busy    (mult_busy_s),
        .last    (last_s),
        .product (product_s)
    );

    // Next-state, result update and done generation.
    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        done_d   = 1'b0;
        load_s   = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    case (bus.op)
                        OP_ADD, OP_AND, OP_XOR: state_d = EXEC;
                        OP_MUL: begin
                            state_d = MUL;
                            load_s  = 1'b1;
                        end
                        OP_RST:  result_d = 16'h0000;
                        default: state_d  = IDLE;
                    endcase
                end else begin
                    state_d = IDLE;
                end
            end
            EXEC: begin
                result_d = alu_logic(op_q, a_q, b_q);
                done_d   = 1'b1;
                state_d  = IDLE;
            end
            MUL: begin
                if (last_s) begin
                    result_d = product_s;
                    done_d   = 1'b1;
                    state_d  = IDLE;
                end else if (!mult_busy_s) begin
                    // Multiplier lost its run without finishing: drop back silently.
                    state_d = IDLE;
                end else begin
                    state_d = MUL;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, start history, operand capture and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            start_q  <= 1'b1;
            a_q      <= 8'h00;
            b_q      <= 8'h00;
            op_q     <= 3'b000;
            result_q <= 16'h0000;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            start_q  <= bus.start;
            result_q <= result_d;
            done_q   <= done_d;
            busy_q   <= (state_d != IDLE);
            if (accept_s) begin
                a_q  <= bus.A;
                b_q  <= bus.B;
                op_q <= bus.op;
            end else begin
                op_q <= op_q;
            end
        end
    end

    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.busy   = busy_q;

endmodule
